calc_seq_controller: RTL and testbench
======================================

Name: calc_seq_controller

Overview:
- Parametrised successor to the 16-bit calculator general controller.
- Accepts keypad digits, sign toggle, operator, equal and clear inputs, and builds signed WIDTH-bit operands by internal shift-add (x*10 = (x<<3)+(x<<1)); no multiplier is used for digit entry.
- Issues one operation per equal press to an external arithmetic unit (add, sub or mult) over a start/done handshake.
- Supports chained operations, overflow/error reporting and a handshake timeout.

Parameters:
- WIDTH, 16: operand/result width, two's complement.
- MAX_DIGITS, 4: maximum decimal digits accepted per operand.
- TIMEOUT, 255: cycles spent in WAIT before declaring error.

Ports:
- clk  in  1  system clock.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- keypad_input  in  4  BCD digit.
- digit_valid  in  1  single-cycle strobe: accept keypad_input.
- negate_input  in  1  strobe: toggle sign of the operand being entered.
- operator_input  in  3  one-hot: 001 add, 010 sub, 100 mult.
- op_valid  in  1  strobe: accept operator_input.
- equal_input  in  1  strobe: execute.
- clear_input  in  1  strobe: clear all.
- alu_start  out  1  one-cycle request pulse.
- alu_a  out  WIDTH  operand 1, held stable from the start pulse until done.
- alu_b  out  WIDTH  operand 2, held stable from the start pulse until done.
- alu_op  out  3  latched one-hot operator.
- alu_done  in  1  result valid, one cycle.
- alu_result  in  WIDTH  result.
- alu_ovf  in  1  overflow, qualified by alu_done.
- display_output  out  WIDTH  value shown.
- complete  out  1  high while showing a valid result.
- error  out  1  high in ERROR state.

Behaviour:
- Reset (sync, RST=1 at clk edge):
  - state=GET_OP1.
  - operands, digit count, sign flag and latched operator cleared.
  - All outputs 0.
- States: GET_OP1, GET_OP2, START, WAIT, SHOW, ERROR.
- Same-cycle priority: clear > equal > op_valid > negate_input > digit_valid. Only the highest-priority strobe acts; the rest are dropped.
- clear_input, any state: next state GET_OP1 with reset values, except RST is not required.
  - If cleared while in WAIT, a later alu_done is ignored.
  - alu_done outside WAIT is always ignored.
- Digit entry (GET_OP1/GET_OP2): accept only if all hold:
  - keypad_input <= 9;
  - digit count < MAX_DIGITS;
  - magnitude*10 + digit <= 2^(WIDTH-1)-1.
  - On accept: magnitude <= magnitude*10 + digit, count++.
  - Otherwise the strobe is ignored with no state change.
- negate_input: toggles the sign flag of the current operand. The operand value is the sign applied to the magnitude, so the result is never -2^(WIDTH-1).
- display_output during entry: the signed current operand, updated the cycle after acceptance.
- op_valid handling:
  - Non-one-hot codes are ignored in all states.
  - GET_OP1: latch operator, go to GET_OP2, display shows 0.
  - GET_OP2 with count=0: replaces the latched operator.
  - GET_OP2 with count>0: ignored.
- equal_input handling:
  - GET_OP2 with count>0: go to START.
  - Ignored in GET_OP1, and in GET_OP2 with count=0.
- START: alu_start=1 for exactly one cycle, with alu_a/alu_b/alu_op valid in the same cycle. Next state WAIT, timeout counter=0.
- WAIT:
  - alu_start=0.
  - The counter increments each cycle.
  - Digit, operator and equal inputs are ignored.
  - alu_done & !alu_ovf: display_output <= alu_result, complete<=1, go to SHOW.
  - alu_done & alu_ovf: go to ERROR.
  - Counter reaching TIMEOUT without done: go to ERROR.
- SHOW (complete=1):
  - Valid digit: start a new operand 1 from that digit, complete<=0, go to GET_OP1.
  - Valid op_valid: chained operation. Operand 1 <= result, operand 2 cleared, go to GET_OP2, complete<=0.
  - equal_input: ignored (no repeat).
  - negate_input: negates the displayed result in place.
- ERROR: error=1, display_output=0, complete=0. Only clear_input or RST exits.
- Latency: equal strobe to alu_start is 1 cycle. alu_done to complete/display is 1 cycle.

Test Plan:
- Digits 1,2,3, op 001, digits 4,5, equal; model returns 168 after 3 cycles -> alu_start single pulse with alu_a=123, alu_b=45, alu_op=001; display_output=168, complete=1.
- Digits 7,0,0,0,0 (MAX_DIGITS=4) -> display 7000, fifth digit ignored. Then digit 0xA -> ignored.
- Digits 5, negate, op 100, digit 3, equal; model returns -15 -> alu_a=0xFFFB, display 0xFFF1. Then op 010, digit 5, equal -> alu_a=0xFFF1, alu_b=5 (chaining).
- Equal with alu_ovf=1 on done -> error=1, display 0. Digits ignored until clear. Clear -> GET_OP1, error=0.
- Model never asserts done -> error=1 exactly TIMEOUT cycles after entering WAIT. Separately: clear mid-WAIT, then late alu_done -> display stays 0, complete=0.
- Same-cycle op_valid+digit_valid in GET_OP1 with count=1 -> operator latched, digit dropped. RST asserted mid-entry -> all outputs 0 next edge.

Source files
------------

// File: rtl/calc_seq_controller.sv
// Calculator sequencing controller.
// Builds two signed operands from keypad digits, issues one ALU operation per
// equal press over a start/done handshake, and shows the result or an error.
//
// state   | meaning
// --------+-----------------------------------------------------------
// GET_OP1 | entering operand 1 (digits / sign toggle / operator)
// GET_OP2 | entering operand 2 (operator may be replaced until a digit)
// START   | one-cycle alu_start pulse, operands presented
// WAIT    | waiting for alu_done, timeout counter running
// SHOW    | result displayed, complete=1, chaining possible
// ERROR   | overflow or timeout, only clear/RST leaves
module calc_seq_controller #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [3:0]       keypad_input,
    input  logic             digit_valid,
    input  logic             negate_input,
    input  logic [2:0]       operator_input,
    input  logic             op_valid,
    input  logic             equal_input,
    input  logic             clear_input,
    output logic             alu_start,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovf,
    output logic [WIDTH-1:0] display_output,
    output logic             complete,
    output logic             error
);

    localparam logic [2:0] GET_OP1 = 3'd0;
    localparam logic [2:0] GET_OP2 = 3'd1;
    localparam logic [2:0] START   = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] SHOW    = 3'd4;
    localparam logic [2:0] ERROR   = 3'd5;

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WIDTH+3:0] MAG_MAX = {5'b00000, {(WIDTH-1){1'b1}}};

    logic [2:0]       state;
    logic [WIDTH-1:0] mag;
    logic             sign;
    logic [CNT_W-1:0] digit_cnt;
    logic [WIDTH-1:0] op1_val;
    logic [TMR_W-1:0] wait_cnt;

    logic [WIDTH+3:0] mag_ext;
    logic [WIDTH+3:0] mag_next_wide;
    logic [WIDTH-1:0] mag_next;
    logic [WIDTH-1:0] cur_val;
    logic             op_onehot;
    logic             digit_ok;
    logic             sel_eq;
    logic             sel_op;
    logic             sel_neg;
    logic             sel_dig;

    // Digit append via shift-add, range checks and strobe priority decode.
    always_comb begin
        mag_ext       = {4'b0000, mag};
        mag_next_wide = (mag_ext << 3) + (mag_ext << 1) + {{WIDTH{1'b0}}, keypad_input};
        mag_next      = mag_next_wide[WIDTH-1:0];
        cur_val       = sign ? -mag : mag;
        op_onehot     = (operator_input == 3'b001) || (operator_input == 3'b010) ||
                        (operator_input == 3'b100);
        digit_ok      = (keypad_input <= 4'd9) && (digit_cnt < CNT_W'(MAX_DIGITS)) &&
                        (mag_next_wide <= MAG_MAX);
        // clear is handled ahead of everything in the sequential block
        sel_eq        = equal_input;
        sel_op        = op_valid & ~equal_input;
        sel_neg       = negate_input & ~op_valid & ~equal_input;
        sel_dig       = digit_valid & ~negate_input & ~op_valid & ~equal_input;
    end

    assign alu_start = (state == START);
    assign error     = (state == ERROR);

    // Main sequencer: operand entry, handshake, result display and error.
    always_ff @(posedge clk) begin
        if (RST || clear_input) begin
            state          <= GET_OP1;
            mag            <= '0;
            sign           <= 1'b0;
            digit_cnt      <= '0;
            op1_val        <= '0;
            wait_cnt       <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= '0;
            display_output <= '0;
            complete       <= 1'b0;
        end else begin
            case (state)
                GET_OP1, GET_OP2: begin
                    if (sel_eq) begin
                        if (state == GET_OP2 && digit_cnt != '0) begin
                            alu_a <= op1_val;
                            alu_b <= cur_val;
                            state <= START;
                        end
                    end else if (sel_op) begin
                        if (op_onehot) begin
                            if (state == GET_OP1) begin
                                op1_val        <= cur_val;
                                alu_op         <= operator_input;
                                mag            <= '0;
                                sign           <= 1'b0;
                                digit_cnt      <= '0;
                                display_output <= '0;
                                state          <= GET_OP2;
                            end else if (digit_cnt == '0) begin
                                alu_op <= operator_input;
                            end
                        end
                    end else if (sel_neg) begin
                        sign           <= ~sign;
                        display_output <= sign ? mag : -mag;
                    end else if (sel_dig && digit_ok) begin
                        mag            <= mag_next;
                        digit_cnt      <= digit_cnt + CNT_W'(1);
                        display_output <= sign ? -mag_next : mag_next;
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (alu_done) begin
                        if (alu_ovf) begin
                            display_output <= '0;
                            state          <= ERROR;
                        end else begin
                            display_output <= alu_result;
                            complete       <= 1'b1;
                            state          <= SHOW;
                        end
                    end else if (wait_cnt == TMR_W'(TIMEOUT - 1)) begin
                        display_output <= '0;
                        state          <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + TMR_W'(1);
                    end
                end
                SHOW: begin
                    if (sel_op) begin
                        if (op_onehot) begin
                            op1_val        <= display_output;
                            alu_op         <= operator_input;
                            mag            <= '0;
                            sign           <= 1'b0;
                            digit_cnt      <= '0;
                            display_output <= '0;
                            complete       <= 1'b0;
                            state          <= GET_OP2;
                        end
                    end else if (sel_neg) begin
                        display_output <= -display_output;
                    end else if (sel_dig && keypad_input <= 4'd9) begin
                        mag            <= {{(WIDTH-4){1'b0}}, keypad_input};
                        sign           <= 1'b0;
                        digit_cnt      <= CNT_W'(1);
                        display_output <= {{(WIDTH-4){1'b0}}, keypad_input};
                        complete       <= 1'b0;
                        state          <= GET_OP1;
                    end
                end
                ERROR: begin
                end
                default: state <= GET_OP1;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_controller.sv
// Scoreboard bench for calc_seq_controller: a behavioural calculator model
// predicts every change of the observable outputs, a monitor compares them.
module tb_calc_seq_controller;

    localparam int W    = 16;
    localparam int MAXD = 4;
    localparam int TMO  = 255;
    localparam int M_OP1 = 0, M_OP2 = 1, M_START = 2, M_WAIT = 3, M_SHOW = 4, M_ERR = 5;

    logic         clk = 1'b0;
    logic         RST = 1'b0;
    logic [3:0]   keypad_input = '0;
    logic         digit_valid = 1'b0;
    logic         negate_input = 1'b0;
    logic [2:0]   operator_input = '0;
    logic         op_valid = 1'b0;
    logic         equal_input = 1'b0;
    logic         clear_input = 1'b0;
    logic         alu_start;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_op;
    logic         alu_done = 1'b0;
    logic [W-1:0] alu_result = '0;
    logic         alu_ovf = 1'b0;
    logic [W-1:0] display_output;
    logic         complete;
    logic         error;

    always #5 clk = ~clk;

    calc_seq_controller #(.WIDTH(W), .MAX_DIGITS(MAXD), .TIMEOUT(TMO)) dut (
        .clk(clk), .RST(RST), .keypad_input(keypad_input), .digit_valid(digit_valid),
        .negate_input(negate_input), .operator_input(operator_input), .op_valid(op_valid),
        .equal_input(equal_input), .clear_input(clear_input), .alu_start(alu_start),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_done(alu_done),
        .alu_result(alu_result), .alu_ovf(alu_ovf), .display_output(display_output),
        .complete(complete), .error(error)
    );

    typedef struct packed {
        logic         start;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] disp;
        logic         comp;
        logic         err;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // calculator model
    int           m_mode = M_OP1;
    int           m_mag = 0;
    bit           m_neg = 0;
    int           m_cnt = 0;
    int           m_op1 = 0;
    logic [2:0]   m_op = '0;
    int           m_disp = 0;
    bit           m_comp = 0;
    int           m_wc = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    obs_t         pred_prev;
    bit           pred_first = 1;

    // ALU responder knobs
    int           lat = 0;
    logic [W-1:0] pend_res = '0;
    bit           pend_ovf = 0;
    bit           force_done = 0;
    bit           force_ovf = 0;
    bit           alu_never = 0;
    bit           rand_mode = 0;
    int           fixed_lat = -1;

    function automatic int wrapw(input int x);
        logic signed [W-1:0] t;
        t = x[W-1:0];
        return int'(t);
    endfunction

    function automatic bit is_onehot(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    function automatic int opval();
        return m_neg ? -m_mag : m_mag;
    endfunction

    task automatic model_step();
        int   sel;
        int   ai;
        int   bi;
        int   r;
        obs_t p;
        if (RST || clear_input) begin
            m_mode = M_OP1; m_mag = 0; m_neg = 0; m_cnt = 0; m_op1 = 0; m_op = '0;
            m_disp = 0; m_comp = 0; m_a = '0; m_b = '0; m_wc = 0;
        end else begin
            sel = equal_input ? 1 : op_valid ? 2 : negate_input ? 3 : digit_valid ? 4 : 0;
            case (m_mode)
                M_OP1, M_OP2: begin
                    if (sel == 1) begin
                        if (m_mode == M_OP2 && m_cnt > 0) begin
                            m_a = W'(m_op1);
                            m_b = W'(opval());
                            m_mode = M_START;
                        end
                    end else if (sel == 2) begin
                        if (is_onehot(operator_input)) begin
                            if (m_mode == M_OP1) begin
                                m_op1 = opval(); m_op = operator_input;
                                m_mag = 0; m_neg = 0; m_cnt = 0; m_disp = 0;
                                m_mode = M_OP2;
                            end else if (m_cnt == 0) begin
                                m_op = operator_input;
                            end
                        end
                    end else if (sel == 3) begin
                        m_neg = !m_neg;
                        m_disp = opval();
                    end else if (sel == 4) begin
                        if (keypad_input <= 9 && m_cnt < MAXD &&
                            m_mag * 10 + int'(keypad_input) <= (1 << (W - 1)) - 1) begin
                            m_mag = m_mag * 10 + int'(keypad_input);
                            m_cnt++;
                            m_disp = opval();
                        end
                    end
                end
                M_START: begin
                    m_mode = M_WAIT;
                    m_wc = 0;
                end
                M_WAIT: begin
                    if (alu_done) begin
                        if (alu_ovf) begin
                            m_mode = M_ERR; m_disp = 0;
                        end else begin
                            m_disp = wrapw(int'($signed(alu_result)));
                            m_comp = 1; m_mode = M_SHOW;
                        end
                    end else begin
                        m_wc++;
                        if (m_wc == TMO) begin
                            m_mode = M_ERR; m_disp = 0;
                        end
                    end
                end
                M_SHOW: begin
                    if (sel == 2) begin
                        if (is_onehot(operator_input)) begin
                            m_op1 = m_disp; m_op = operator_input;
                            m_mag = 0; m_neg = 0; m_cnt = 0; m_disp = 0; m_comp = 0;
                            m_mode = M_OP2;
                        end
                    end else if (sel == 3) begin
                        m_disp = wrapw(-m_disp);
                    end else if (sel == 4) begin
                        if (keypad_input <= 9) begin
                            m_mag = int'(keypad_input); m_cnt = 1; m_neg = 0;
                            m_disp = m_mag; m_comp = 0; m_mode = M_OP1;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (m_mode == M_START) begin
            ai = int'($signed(m_a));
            bi = int'($signed(m_b));
            if (m_op == 3'b001)      r = ai + bi;
            else if (m_op == 3'b010) r = ai - bi;
            else                     r = ai * bi;
            pend_ovf = (r > 32767) || (r < -32768) || force_ovf;
            pend_res = W'(r);
            if (alu_never)             lat = 100000;
            else if (fixed_lat >= 0)   lat = fixed_lat;
            else if (rand_mode && $urandom_range(0, 39) == 0) lat = 100000;
            else                       lat = $urandom_range(0, 6);
        end
        p.start = (m_mode == M_START);
        p.a     = m_a;
        p.b     = m_b;
        p.op    = m_op;
        p.disp  = W'(m_disp);
        p.comp  = m_comp;
        p.err   = (m_mode == M_ERR);
        if (pred_first || p != pred_prev) exp_q.push_back('{edge_n + 1, p});
        pred_prev  = p;
        pred_first = 0;
    endtask

    task automatic step();
        alu_done = 1'b0; alu_ovf = 1'b0; alu_result = '0;
        if (m_mode == M_WAIT) begin
            if (lat == 0) begin
                alu_done = 1'b1; alu_result = pend_res; alu_ovf = pend_ovf;
            end else begin
                lat--;
            end
        end else if (force_done || (rand_mode && $urandom_range(0, 99) == 0)) begin
            alu_done = 1'b1; alu_result = W'($urandom); alu_ovf = 1'($urandom_range(0, 1));
        end
        force_done = 0;
        model_step();
        @(posedge clk);
        #1;
        RST = 1'b0; digit_valid = 1'b0; negate_input = 1'b0; op_valid = 1'b0;
        equal_input = 1'b0; clear_input = 1'b0; alu_done = 1'b0;
    endtask

    task automatic dig(input int d);
        digit_valid = 1'b1; keypad_input = 4'(d); step();
    endtask
    task automatic opr(input logic [2:0] o);
        op_valid = 1'b1; operator_input = o; step();
    endtask
    task automatic eq();
        equal_input = 1'b1; step();
    endtask
    task automatic neg();
        negate_input = 1'b1; step();
    endtask
    task automatic clr();
        clear_input = 1'b1; step();
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: every change of the observable outputs must match the next prediction.
    obs_t cur_o;
    obs_t last_o;
    bit   first_seen = 1;
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            cur_o = {alu_start, alu_a, alu_b, alu_op, display_output, complete, error};
            if (first_seen || cur_o !== last_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cycle=%0d got start=%0b a=%h b=%h op=%b disp=%h comp=%0b err=%0b",
                             edge_n, cur_o.start, cur_o.a, cur_o.b, cur_o.op, cur_o.disp, cur_o.comp, cur_o.err);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != edge_n || e.o !== cur_o) begin
                        errors++;
                        $display("FAIL output_event cycle=%0d got start=%0b a=%h b=%h op=%b disp=%h comp=%0b err=%0b ; expected cycle=%0d start=%0b a=%h b=%h op=%b disp=%h comp=%0b err=%0b",
                                 edge_n, cur_o.start, cur_o.a, cur_o.b, cur_o.op, cur_o.disp, cur_o.comp, cur_o.err,
                                 e.cyc, e.o.start, e.o.a, e.o.b, e.o.op, e.o.disp, e.o.comp, e.o.err);
                    end
                end
                last_o     = cur_o;
                first_seen = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; step();
        idle(2);
        // 123 + 45
        fixed_lat = 2;
        dig(1); dig(2); dig(3); opr(3'b001); dig(4); dig(5); eq(); idle(6);
        // digit limit and invalid key
        clr(); dig(7); dig(0); dig(0); dig(0); dig(0); dig(10); idle(1);
        // negative operand, mult, then chained sub
        clr(); dig(5); neg(); opr(3'b100); dig(3); eq(); idle(6);
        opr(3'b010); dig(5); eq(); idle(6);
        // SHOW: negate, equal ignored, new digit restarts
        neg(); eq(); idle(2); dig(8); idle(1);
        // forced overflow, digits ignored in ERROR
        clr(); force_ovf = 1; dig(2); opr(3'b001); dig(3); eq(); idle(6);
        force_ovf = 0; dig(4); opr(3'b001); idle(2); clr();
        // timeout
        alu_never = 1; dig(1); opr(3'b001); dig(1); eq(); idle(TMO + 5); clr(); alu_never = 0;
        // clear mid-WAIT, late done ignored
        fixed_lat = 10; dig(1); opr(3'b010); dig(1); eq(); idle(3); clr(); idle(2);
        force_done = 1; step(); idle(3);
        fixed_lat = -1;
        // operator replacement, magnitude limit
        opr(3'b001); dig(9); dig(9); dig(9); opr(3'b100); opr(3'b010); dig(3); dig(2); dig(7); dig(6); dig(8);
        opr(3'b011); eq(); idle(10); clr();
        dig(3); dig(2); dig(7); dig(6); dig(8); idle(1);
        // same-cycle op_valid + digit_valid
        clr(); dig(1);
        op_valid = 1'b1; operator_input = 3'b001; digit_valid = 1'b1; keypad_input = 4'd2; step();
        dig(6); idle(1);
        // RST mid-entry
        dig(4); RST = 1'b1; step(); idle(2);
        // randomized phase
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            RST          = ($urandom_range(0, 299) == 0);
            clear_input  = ($urandom_range(0, 59) == 0);
            equal_input  = ($urandom_range(0, 9) == 0);
            op_valid     = ($urandom_range(0, 9) == 0);
            operator_input = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                                         : 3'(1 << $urandom_range(0, 2));
            negate_input = ($urandom_range(0, 14) == 0);
            digit_valid  = ($urandom_range(0, 2) == 0);
            keypad_input = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
            step();
        end
        rand_mode = 0;
        idle(3);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d unobserved expected events, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
